// File: rtl/priority_grant_arbiter.sv
// priority_grant_arbiter: shares one resource among N_REQ requesters with fixed or
// round-robin selection, grant locking while the owner keeps requesting, and an optional hold limit.
`default_nettype none

module priority_grant_arbiter #(
    parameter int N_REQ    = 16,
    parameter int IDX_W    = 4,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             arb_en,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             preempt
);

    localparam int               HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0]  HOLD_SAT  = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic [N_REQ-1:0] grant_q,   grant_d;
    logic             valid_q,   valid_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             preempt_q, preempt_d;
    logic [HC_W-1:0]  hold_q,    hold_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;

    logic [IDX_W-1:0] win_idx;
    logic             any_req;
    logic             owner_req;
    logic             others_req;
    logic             at_limit;

    assign any_req    = |req;
    assign owner_req  = |(req & grant_q);
    assign others_req = |(req & ~grant_q);
    assign at_limit   = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST);

    // Later assignments win: in RR mode indices at or below ptr override those above it,
    // which is a downward search from ptr that wraps to N_REQ-1.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && ((RR_EN == 0) || (IDX_W'(i) > ptr_q))) begin
                win_idx = IDX_W'(i);
            end
        end
        if (RR_EN != 0) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && (IDX_W'(i) <= ptr_q)) begin
                    win_idx = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= PTR_RST;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arb_en && any_req) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!owner_req || (at_limit && others_req)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = '0;
        valid_d   = 1'b0;
        idx_d     = '0;
        preempt_d = 1'b0;
        hold_d    = '0;
        ptr_d     = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (arb_en && any_req) begin
                    grant_d = N_REQ'(1) << win_idx;
                    valid_d = 1'b1;
                    idx_d   = win_idx;
                    ptr_d   = (win_idx == '0) ? PTR_RST : win_idx - 1'b1;
                end
            end
            S_BUSY: begin
                // Release outranks preemption, so preempt only fires while the owner still requests.
                if (owner_req) begin
                    if (at_limit && others_req) begin
                        preempt_d = 1'b1;
                    end else begin
                        grant_d = grant_q;
                        valid_d = 1'b1;
                        idx_d   = idx_q;
                        hold_d  = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign preempt     = preempt_q;

endmodule

`default_nettype wire
